// File: rtl/multi_lane_bank_read_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : multi_lane_bank_read_scheduler
//  Description : Maps multi-lane operand reads onto TID-swizzled register-file
//                banks and issues them as conflict-free beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_lane_bank_read_scheduler #(
    parameter int NUM_REGS  = 32,
    parameter int NUM_BANKS = 32,
    parameter int NUM_LANES = 4,
    parameter int TID_W     = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [NUM_REGS-1:0]               req_reg_bitmap,
    input  logic [NUM_LANES-1:0]              req_lane_mask,
    input  logic [NUM_LANES*TID_W-1:0]        req_tid,
    output logic                              gnt_valid,
    input  logic                              gnt_ready,
    output logic [NUM_BANKS-1:0]              gnt_bank_bitmap,
    output logic [NUM_LANES*NUM_REGS-1:0]     gnt_lane_regs,
    output logic                              gnt_last,
    output logic [$clog2(NUM_LANES+1)-1:0]    gnt_beat,
    output logic                              busy
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int BEAT_W = $clog2(NUM_LANES + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                               state_q, state_d;
    logic [NUM_LANES-1:0][NUM_REGS-1:0]   pending_q, pending_d;
    logic [NUM_LANES-1:0][BANK_W-1:0]     tid_q, tid_d;
    logic [BEAT_W-1:0]                    beat_q, beat_d;

    logic [NUM_LANES-1:0][NUM_REGS-1:0]   grant;
    logic [NUM_LANES-1:0][NUM_REGS-1:0]   remain;
    logic [NUM_LANES-1:0][NUM_REGS-1:0][BANK_W-1:0] bank_map;
    logic [NUM_BANKS-1:0]                 claimed;
    logic                                 beat_last;
    logic                                 unused_tid_bits;

    // Only tid mod NUM_BANKS matters, so upper TID bits are never stored.
    assign unused_tid_bits = ^req_tid;

    // Quadrant g of the TID selects offset bitrev2(g) * NUM_BANKS/4.
    function automatic logic [BANK_W-1:0] bank_of(input logic [BANK_W-1:0] t,
                                                  input int unsigned r);
        logic [BANK_W-1:0] off;
        off             = '0;
        off[BANK_W-1]   = t[BANK_W-2];
        off[BANK_W-2]   = t[BANK_W-1];
        return t + BANK_W'(r) + off;
    endfunction

    for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
        for (genvar gr = 0; gr < NUM_REGS; gr++) begin : g_reg
            assign bank_map[gl][gr] = bank_of(tid_q[gl], gr);
        end
    end

    always_comb begin
        grant   = '0;
        claimed = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (pending_q[l][r] && !claimed[bank_map[l][r]]) begin
                    grant[l][r]               = 1'b1;
                    claimed[bank_map[l][r]]   = 1'b1;
                end
            end
        end
        remain    = pending_q & ~grant;
        beat_last = (remain == '0);
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        tid_d     = tid_q;
        beat_d    = beat_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        pending_d[l] = req_lane_mask[l] ? req_reg_bitmap : '0;
                        tid_d[l]     = req_tid[l*TID_W +: BANK_W];
                    end
                    beat_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (gnt_ready) begin
                    pending_d = remain;
                    beat_d    = beat_q + BEAT_W'(1);
                    if (beat_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            tid_q     <= '0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            tid_q     <= tid_d;
            beat_q    <= beat_d;
        end
    end

    assign busy            = (state_q == S_ISSUE);
    assign gnt_valid       = busy;
    assign req_ready       = rst_n && !busy;
    assign gnt_bank_bitmap = busy ? claimed : '0;
    assign gnt_lane_regs   = busy ? grant : '0;
    assign gnt_last        = busy && beat_last;
    assign gnt_beat        = busy ? beat_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_multi_lane_bank_read_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_lane_bank_read_scheduler
//  Description : Randomized self-checking bench with a behavioural beat model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_lane_bank_read_scheduler;

    localparam int NR = 32;
    localparam int NB = 32;
    localparam int NL = 4;
    localparam int TW = 5;
    localparam int BW = $clog2(NL + 1);

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [NR-1:0]     req_reg_bitmap;
    logic [NL-1:0]     req_lane_mask;
    logic [NL*TW-1:0]  req_tid;
    logic              gnt_valid;
    logic              gnt_ready;
    logic [NB-1:0]     gnt_bank_bitmap;
    logic [NL*NR-1:0]  gnt_lane_regs;
    logic              gnt_last;
    logic [BW-1:0]     gnt_beat;
    logic              busy;

    multi_lane_bank_read_scheduler #(
        .NUM_REGS (NR),
        .NUM_BANKS(NB),
        .NUM_LANES(NL),
        .TID_W    (TW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_reg_bitmap (req_reg_bitmap),
        .req_lane_mask  (req_lane_mask),
        .req_tid        (req_tid),
        .gnt_valid      (gnt_valid),
        .gnt_ready      (gnt_ready),
        .gnt_bank_bitmap(gnt_bank_bitmap),
        .gnt_lane_regs  (gnt_lane_regs),
        .gnt_last       (gnt_last),
        .gnt_beat       (gnt_beat),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0]    banks;
        logic [NL*NR-1:0] regs;
        bit               last;
        int               beat;
    } beat_t;

    beat_t exp_q[$];
    beat_t cur;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bank from the swizzle formula using plain integer arithmetic.
    function automatic int model_bank(input int tid, input int r);
        int t, q, g, rev;
        t   = tid % NB;
        q   = NB / 4;
        g   = t / q;
        rev = ((g % 2) * 2) + (g / 2);
        return (t + r + rev * q) % NB;
    endfunction

    // Expand a request into its full list of greedy conflict-free beats.
    task automatic build(input logic [NL-1:0] mask, input logic [NR-1:0] bm,
                         input logic [NL*TW-1:0] tids);
        bit    pend[NL][NR];
        bit    used[NB];
        int    left;
        int    b;
        int    k;
        beat_t e;
        left = 0;
        b    = 0;
        for (int l = 0; l < NL; l++)
            for (int r = 0; r < NR; r++) begin
                pend[l][r] = mask[l] && bm[r];
                if (pend[l][r]) left++;
            end
        do begin
            for (int i = 0; i < NB; i++) used[i] = 1'b0;
            e.banks = '0;
            e.regs  = '0;
            for (int l = 0; l < NL; l++)
                for (int r = 0; r < NR; r++)
                    if (pend[l][r]) begin
                        k = model_bank(int'(tids[l*TW +: TW]), r);
                        if (!used[k]) begin
                            used[k]            = 1'b1;
                            pend[l][r]         = 1'b0;
                            left--;
                            e.banks[k]         = 1'b1;
                            e.regs[l*NR + r]   = 1'b1;
                        end
                    end
            e.last = (left == 0);
            e.beat = b;
            b++;
            exp_q.push_back(e);
        end while (left > 0);
    endtask

    always @(posedge clk) begin
        if (!rst_n)
            exp_q.delete();
        else if (exp_q.size() != 0) begin
            if (gnt_ready) void'(exp_q.pop_front());
        end else if (req_valid)
            build(req_lane_mask, req_reg_bitmap, req_tid);
    end

    always @(negedge clk) begin
        if (exp_q.size() == 0) begin
            chk("idle_valid", gnt_valid, 0);
            chk("idle_busy", busy, 0);
            chk("idle_last", gnt_last, 0);
        end else begin
            cur = exp_q[0];
            chk("valid", gnt_valid, 1);
            chk("busy", busy, 1);
            chk("banks", gnt_bank_bitmap, cur.banks);
            chk("lane_regs", gnt_lane_regs, cur.regs);
            chk("last", gnt_last, cur.last);
            chk("beat", gnt_beat, cur.beat);
        end
        chk("req_ready", req_ready, rst_n && (exp_q.size() == 0));
    end

    task automatic send(input logic [NL-1:0] mask, input logic [NR-1:0] bm,
                        input logic [NL*TW-1:0] tids);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: req_ready stayed 0, required 1");
        end
        req_valid      = 1'b1;
        req_lane_mask  = mask;
        req_reg_bitmap = bm;
        req_tid        = tids;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            if (n >= 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL idle_timeout: busy stayed 1, required 0");
                break;
            end
            n++;
            if (rnd) begin
                gnt_ready      = ($urandom_range(0, 9) < 7);
                req_valid      = ($urandom_range(0, 3) == 0);
                req_tid        = NL*TW'($urandom);
                req_lane_mask  = NL'($urandom);
                req_reg_bitmap = $urandom;
            end
        end
        req_valid = 1'b0;
    endtask

    logic [127:0] f_pat;
    logic [NR-1:0] bm_r;

    initial begin
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_reg_bitmap = '0;
        req_lane_mask  = '0;
        req_tid        = '0;
        gnt_ready      = 1'b1;
        f_pat          = 128'hF;

        chk("model_swz_9_0", model_bank(9, 0), 25);
        chk("model_swz_17_0", model_bank(17, 0), 25);
        chk("model_swz_31_1", model_bank(31, 1), 24);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", gnt_valid, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Single lane, first beat visible the cycle after accept
        send(4'b0001, 32'h5, '0);
        @(negedge clk);
        chk("t1_valid", gnt_valid, 1);
        chk("t1_banks", gnt_bank_bitmap, 32'h5);
        chk("t1_regs", gnt_lane_regs, 128'h5);
        chk("t1_last", gnt_last, 1);
        chk("t1_beat", gnt_beat, 0);
        wait_idle(0);

        send(4'b0001, 32'h1, 20'd9);
        @(negedge clk);
        chk("swz9_banks", gnt_bank_bitmap, 32'h0200_0000);
        wait_idle(0);
        send(4'b0001, 32'h1, 20'd17);
        @(negedge clk);
        chk("swz17_banks", gnt_bank_bitmap, 32'h0200_0000);
        wait_idle(0);
        send(4'b0001, 32'h2, 20'd31);
        @(negedge clk);
        chk("swz31_banks", gnt_bank_bitmap, 32'h0100_0000);
        wait_idle(0);

        // Lane 1 reg 0 collides with lane 0 reg 1 on bank 1
        send(4'b0011, 32'h3, {5'd0, 5'd0, 5'd1, 5'd0});
        @(negedge clk);
        chk("cf0_banks", gnt_bank_bitmap, 32'h7);
        chk("cf0_regs", gnt_lane_regs, 128'h0000_0002_0000_0003);
        chk("cf0_last", gnt_last, 0);
        @(negedge clk);
        chk("cf1_banks", gnt_bank_bitmap, 32'h2);
        chk("cf1_regs", gnt_lane_regs, 128'h0000_0001_0000_0000);
        chk("cf1_last", gnt_last, 1);
        chk("cf1_beat", gnt_beat, 1);
        wait_idle(0);

        send(4'b1111, 32'hF, '0);
        for (int l = 0; l < NL; l++) begin
            @(negedge clk);
            chk("four_banks", gnt_bank_bitmap, 32'hF);
            chk("four_regs", gnt_lane_regs, f_pat << (32 * l));
            chk("four_beat", gnt_beat, l);
            chk("four_last", gnt_last, (l == NL - 1));
        end
        wait_idle(0);

        // Stall for three cycles while beat 1 is presented
        send(4'b1111, 32'hF, '0);
        @(negedge clk);
        @(negedge clk);
        gnt_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_beat", gnt_beat, 1);
            chk("stall_banks", gnt_bank_bitmap, 32'hF);
            chk("stall_regs", gnt_lane_regs, f_pat << 32);
        end
        gnt_ready = 1'b1;
        wait_idle(0);

        send(4'b0000, 32'hFFFF_FFFF, '0);
        @(negedge clk);
        chk("empty_banks", gnt_bank_bitmap, 0);
        chk("empty_regs", gnt_lane_regs, 0);
        chk("empty_last", gnt_last, 1);
        chk("empty_beat", gnt_beat, 0);
        wait_idle(0);

        // Reset asserted while beat 1 of a four-beat request is on the bus
        send(4'b1111, 32'hF, '0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("prerst_beat", gnt_beat, 1);
        @(negedge clk);
        chk("rst_mid_valid", gnt_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_last", gnt_last, 0);
        chk("rst_mid_beat", gnt_beat, 0);
        chk("rst_mid_ready", req_ready, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        send(4'b0011, 32'h3, {5'd0, 5'd0, 5'd1, 5'd0});
        @(negedge clk);
        chk("post_rst_banks", gnt_bank_bitmap, 32'h7);
        wait_idle(0);

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 5))
                0:       bm_r = '0;
                1:       bm_r = '1;
                2:       bm_r = $urandom;
                default: bm_r = $urandom & $urandom & $urandom;
            endcase
            gnt_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0)
                send(NL'($urandom), bm_r, {4{5'($urandom)}});
            else
                send(NL'($urandom), bm_r, NL*TW'($urandom));
            wait_idle(1);
            gnt_ready = 1'b1;
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
